stream_rx_checker: RTL and testbench

- Receive-side sink for the 32-bit valid/ready test stream that our benches and traffic generators drive.
- Accepts a programmed number of beats and applies optional periodic backpressure on in_ready.
- Checks each accepted word against an incrementing pattern seeded at start.
- Reports beat count, error count, first mismatching word and a pass flag. Used as the far end of stimulus in standalone RTL benches and in SoC-level smoke tests.

---
 rtl/stream_chk_pkg.sv | 22 ++
 rtl/stream_stall_gen.sv | 31 +++
 rtl/stream_rx_checker.sv | 122 ++++++++++++
 tb/tb_stream_rx_checker.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_chk_pkg.sv
// Shared types for the stream receive checker.
// Holds the FSM states, default widths and a status bundle.
package stream_chk_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_STALL_PERIOD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic                  pass;
    logic [DEF_CNT_W-1:0]  beat_count;
    logic [DEF_CNT_W-1:0]  err_count;
    logic [DEF_DATA_W-1:0] first_err_data;
  } chk_status_t;

endpackage

// File: rtl/stream_stall_gen.sv
// Modulo cycle counter producing the periodic backpressure mask.
// ready_mask drops for one cycle out of every PERIOD enabled cycles.
module stream_stall_gen #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic mask_en,
  output logic ready_mask
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign ready_mask = !(mask_en && (cnt == LAST));

endmodule

// File: rtl/stream_rx_checker.sv
// Receive-side sink: accepts a programmed number of beats and
// checks them against an incrementing pattern seeded at start.
module stream_rx_checker
  import stream_chk_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STALL_PERIOD = DEF_STALL_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  expect_count,
  input  logic [DATA_W-1:0] seed,
  input  logic              stall_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [DATA_W-1:0] first_err_data
);

  chk_state_e        state;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] exp_word;
  logic              stall_en_q;

  logic              ready_mask;
  logic              arm;
  logic              accept;
  logic              mismatch;
  logic              last_beat;
  logic [CNT_W-1:0]  beat_next;
  logic [CNT_W-1:0]  err_next;

  assign arm       = (state == IDLE) && start;
  assign in_ready  = (state == RUN) && ready_mask;
  assign busy      = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign mismatch  = (in_data != exp_word);
  assign beat_next = beat_count + CNT_W'(1);
  assign last_beat = (beat_next == cnt_q);

  // Error counter sticks at all-ones instead of wrapping to zero.
  assign err_next = (mismatch && !(&err_count))
                  ? err_count + CNT_W'(1)
                  : err_count;

  stream_stall_gen #(
    .PERIOD (STALL_PERIOD)
  ) u_stall (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (arm),
    .enable     (state == RUN),
    .mask_en    (stall_en_q),
    .ready_mask (ready_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt_q          <= '0;
      exp_word       <= '0;
      stall_en_q     <= 1'b0;
      beat_count     <= '0;
      err_count      <= '0;
      first_err_data <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_q          <= expect_count;
            exp_word       <= seed;
            stall_en_q     <= stall_en;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            pass           <= 1'b0;
            if (expect_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (accept) begin
            beat_count <= beat_next;
            exp_word   <= exp_word + DATA_W'(1);
            err_count  <= err_next;
            if (mismatch && (err_count == '0)) begin
              first_err_data <= in_data;
            end
            // done and pass land together, pass covering this beat.
            if (last_beat) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rx_checker.sv
// Self-checking bench for stream_rx_checker.
// Drives randomized streams and compares against a pattern model.
module tb_stream_rx_checker;
  import stream_chk_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] expect_count = '0;
  logic [DW-1:0] seed = '0;
  logic          stall_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] beat_count;
  logic [CW-1:0] err_count;
  logic [DW-1:0] first_err_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_rx_checker #(
    .DATA_W       (DW),
    .CNT_W        (CW),
    .STALL_PERIOD (SP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .expect_count   (expect_count),
    .seed           (seed),
    .stall_en       (stall_en),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .beat_count     (beat_count),
    .err_count      (err_count),
    .first_err_data (first_err_data)
  );

  // Observations and model results of the most recent run.
  bit            rdy_trace[$];
  int            acc_n;
  int            last_acc;
  int            done_at;
  int            busy_low;
  bit            timeout;
  bit            rdy_at_done;
  int            m_err;
  logic [DW-1:0] m_first;

  function automatic bit model_ready(bit st, int i);
    return !(st && ((i % SP) == SP - 1));
  endfunction

  // Runs one check from start to done. Inputs change on negedge,
  // outputs are read on negedge before changing.
  task automatic run_stream(
    input logic [DW-1:0] s,
    input int            n,
    input bit            st,
    input int            vpct,
    input int            bad_idx,
    input logic [DW-1:0] bad_word,
    input int            epct,
    input int            restart_at
  );
    logic [DW-1:0] want;
    int i;
    rdy_trace.delete();
    acc_n = 0; last_acc = -1; done_at = -1; busy_low = 0;
    timeout = 0; rdy_at_done = 0; m_err = 0; m_first = '0;
    @(negedge clk);
    start = 1'b1; seed = s;
    expect_count = CW'(n); stall_en = st;
    @(negedge clk);
    start = 1'b0;
    seed = $urandom;
    expect_count = CW'($urandom);
    stall_en = 1'($urandom);
    i = 0;
    forever begin
      if (done) begin
        done_at = i;
        rdy_at_done = in_ready;
        break;
      end
      if (i >= 300) begin
        timeout = 1;
        break;
      end
      rdy_trace.push_back(in_ready);
      if (!busy) busy_low++;
      start = (i == restart_at);
      want = s + DW'(acc_n);
      in_valid = ($urandom_range(99) < vpct);
      in_data = want;
      if (acc_n == bad_idx) begin
        in_data = bad_word;
      end else if (epct > 0 && $urandom_range(99) < epct) begin
        in_data = want ^ (DW'(1) << $urandom_range(DW - 1));
      end
      if (in_valid && in_ready) begin
        if (in_data != want) begin
          if (m_err == 0) m_first = in_data;
          m_err++;
        end
        acc_n++;
        last_acc = i;
      end
      @(negedge clk);
      i++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, pass, beat_count, err_count,
         first_err_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b busy=%0b done=%0b pass=%0b beats=%0d errs=%0d first=%h, want all 0",
               in_ready, busy, done, pass, beat_count, err_count,
               first_err_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    run_stream(32'h12345678, 4, 0, 100, -1, '0, 0, -1);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL %s_timeout: no done within bound", tag);
    end
    checks++;
    if (acc_n != 4 || rdy_trace.size() != 4) begin
      errors++;
      $display("FAIL %s_accepts: got %0d accepts in %0d cycles, want 4 in 4",
               tag, acc_n, rdy_trace.size());
    end
    checks++;
    if (done_at != 4) begin
      errors++;
      $display("FAIL %s_done_latency: done at cycle %0d, want 4", tag, done_at);
    end
    checks++;
    if (pass !== 1'b1 || beat_count !== 16'd4 || err_count !== 16'd0
        || first_err_data !== '0) begin
      errors++;
      $display("FAIL %s_status: got pass=%0b beats=%0d errs=%0d first=%h, want 1 4 0 0",
               tag, pass, beat_count, err_count, first_err_data);
    end
    checks++;
    if (rdy_at_done !== 1'b0 || busy_low != 0) begin
      errors++;
      $display("FAIL %s_ready_busy: rdy_at_done=%0b busy_low=%0d, want 0 0",
               tag, rdy_at_done, busy_low);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass !== 1'b1 || beat_count !== 16'd4) begin
      errors++;
      $display("FAIL %s_after_done: got done=%0b pass=%0b beats=%0d, want 0 1 4",
               tag, done, pass, beat_count);
    end
  endtask

  task automatic test_error();
    run_stream(32'h12345678, 4, 0, 100, 2, 32'hDEADBEEF, 0, -1);
    checks++;
    if (timeout || err_count !== 16'd1 || first_err_data !== 32'hDEADBEEF
        || pass !== 1'b0 || beat_count !== 16'd4) begin
      errors++;
      $display("FAIL error_beat: got to=%0b errs=%0d first=%h pass=%0b beats=%0d, want 0 1 deadbeef 0 4",
               timeout, err_count, first_err_data, pass, beat_count);
    end
  endtask

  task automatic test_stall();
    run_stream(32'hA5A50000, 8, 1, 100, -1, '0, 0, -1);
    checks++;
    if (timeout || acc_n != 8 || rdy_trace.size() != 10
        || done_at != 10) begin
      errors++;
      $display("FAIL stall_cycles: got to=%0b accepts=%0d cycles=%0d done_at=%0d, want 0 8 10 10",
               timeout, acc_n, rdy_trace.size(), done_at);
    end
    foreach (rdy_trace[k]) begin
      checks++;
      if (rdy_trace[k] != model_ready(1'b1, k)) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %0b want %0b",
                 k, rdy_trace[k], model_ready(1'b1, k));
      end
    end
    checks++;
    if (pass !== 1'b1 || beat_count !== 16'd8) begin
      errors++;
      $display("FAIL stall_status: got pass=%0b beats=%0d, want 1 8",
               pass, beat_count);
    end
  endtask

  task automatic test_wrap();
    run_stream(32'hFFFFFFFE, 3, 0, 100, -1, '0, 0, -1);
    checks++;
    if (timeout || pass !== 1'b1 || beat_count !== 16'd3
        || err_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap: got to=%0b pass=%0b beats=%0d errs=%0d, want 0 1 3 0",
               timeout, pass, beat_count, err_count);
    end
  endtask

  task automatic test_zero_count();
    run_stream(32'h0BAD0BAD, 0, 0, 100, -1, '0, 0, -1);
    checks++;
    if (done_at != 0 || acc_n != 0 || pass !== 1'b1
        || beat_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_count: got done_at=%0d accepts=%0d pass=%0b beats=%0d, want 0 0 1 0",
               done_at, acc_n, pass, beat_count);
    end
  endtask

  task automatic test_start_ignored();
    run_stream(32'h00C0FFEE, 5, 0, 100, -1, '0, 0, 2);
    checks++;
    if (timeout || acc_n != 5 || beat_count !== 16'd5 || pass !== 1'b1
        || done_at != 5) begin
      errors++;
      $display("FAIL start_ignored: got to=%0b accepts=%0d beats=%0d pass=%0b done_at=%0d, want 0 5 5 1 5",
               timeout, acc_n, beat_count, pass, done_at);
    end
  endtask

  task automatic test_reset_midrun();
    bit seen_done;
    @(negedge clk);
    start = 1'b1; seed = 32'h12345678;
    expect_count = 16'd4; stall_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 32'h12345678 + DW'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (beat_count !== 16'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_progress: got beats=%0d busy=%0b, want 2 1",
               beat_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, pass, beat_count, err_count,
         first_err_data} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%0b busy=%0b done=%0b beats=%0d, want all 0",
               in_ready, busy, done, beat_count);
    end
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL midrun_no_done: got done pulse, want none");
    end
    test_basic("after_reset");
  endtask

  task automatic test_random();
    int n;
    bit st;
    logic [DW-1:0] s;
    for (int r = 0; r < 20; r++) begin
      s = $urandom;
      n = $urandom_range(24, 1);
      st = 1'($urandom);
      run_stream(s, n, st, $urandom_range(100, 50), -1, '0, 25, -1);
      checks++;
      if (timeout || acc_n != n || done_at != last_acc + 1) begin
        errors++;
        $display("FAIL rand%0d_flow: got to=%0b accepts=%0d done_at=%0d last=%0d, want 0 %0d last+1",
                 r, timeout, acc_n, done_at, last_acc, n);
      end
      checks++;
      if (beat_count !== CW'(n) || err_count !== CW'(m_err)
          || first_err_data !== m_first || pass !== (m_err == 0)) begin
        errors++;
        $display("FAIL rand%0d_status: got beats=%0d errs=%0d first=%h pass=%0b, want %0d %0d %h %0b",
                 r, beat_count, err_count, first_err_data, pass,
                 n, m_err, m_first, (m_err == 0));
      end
      foreach (rdy_trace[k]) begin
        checks++;
        if (rdy_trace[k] != model_ready(st, k)) begin
          errors++;
          $display("FAIL rand%0d_ready[%0d]: got %0b want %0b",
                   r, k, rdy_trace[k], model_ready(st, k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_error();
    test_stall();
    test_wrap();
    test_zero_count();
    test_start_ignored();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
